alu_md: RTL and testbench

ALU_MD -- requirements
Module: alu_md

---
 rtl/alu_md_pkg.sv | 40 ++++
 rtl/alu_md_if.sv | 15 +
 rtl/alu_core.sv | 45 ++++
 rtl/alu_md.sv | 167 ++++++++++++++++
 tb/tb_alu_md.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_md_pkg.sv
// Shared op-code constants, FSM state type and latency constants for alu_md.
package alu_md_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    // Base ops (op[4] = 0); LT/LTU share the SLT/SLTU encodings
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_JALR = 4'd10;
    localparam logic [3:0] OP_EQ   = 4'd11;
    localparam logic [3:0] OP_NE   = 4'd12;
    localparam logic [3:0] OP_GE   = 4'd13;
    localparam logic [3:0] OP_GEU  = 4'd14;
    localparam logic [3:0] OP_LT   = OP_SLT;
    localparam logic [3:0] OP_LTU  = OP_SLTU;
    localparam logic [3:0] OP_BAD  = 4'd15;

    // M ops (op[4] = 1, op[3] = 0)
    localparam logic [2:0] M_MUL    = 3'd0;
    localparam logic [2:0] M_MULH   = 3'd1;
    localparam logic [2:0] M_MULHSU = 3'd2;
    localparam logic [2:0] M_MULHU  = 3'd3;
    localparam logic [2:0] M_DIV    = 3'd4;
    localparam logic [2:0] M_DIVU   = 3'd5;
    localparam logic [2:0] M_REM    = 3'd6;
    localparam logic [2:0] M_REMU   = 3'd7;

    // Iterative ops finish XLEN + LAT_ITER_EXTRA edges after the start
    localparam int LAT_BASE       = 1;
    localparam int LAT_ITER_EXTRA = 2;

endpackage

// File: rtl/alu_md_if.sv
// Request/result bundle between an alu_md user (master) and the unit (slave).
interface alu_md_if #(parameter int XLEN = 32);
    logic            start;
    logic [4:0]      op;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] Q;
    logic            Z;
    logic            err;

    modport master (output start, op, A, B, input busy, done, Q, Z, err);
    modport slave  (input start, op, A, B, output busy, done, Q, Z, err);
endinterface

// File: rtl/alu_core.sv
// Combinational base-op datapath: add/sub, logic, shifts, compares, branch predicates.
module alu_core
    import alu_md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      op,
    output logic [XLEN-1:0] result
);
    localparam int SW = $clog2(XLEN);

    logic [XLEN-1:0] sum;
    logic [SW-1:0]   shamt;
    logic            lt;
    logic            ltu;

    assign sum   = a + b;
    assign shamt = b[SW-1:0];
    assign lt    = $signed(a) < $signed(b);
    assign ltu   = a < b;

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = sum;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLL:  result = a << shamt;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = $unsigned($signed(a) >>> shamt);
            OP_SLT:  result = {{(XLEN-1){1'b0}}, lt};
            OP_SLTU: result = {{(XLEN-1){1'b0}}, ltu};
            OP_JALR: result = {sum[XLEN-1:1], 1'b0};
            OP_EQ:   result = {{(XLEN-1){1'b0}}, a == b};
            OP_NE:   result = {{(XLEN-1){1'b0}}, a != b};
            OP_GE:   result = {{(XLEN-1){1'b0}}, ~lt};
            OP_GEU:  result = {{(XLEN-1){1'b0}}, ~ltu};
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/alu_md.sv
// ALU with iterative RISC-V M-extension unit; the divider is only built when ALU_MD_DIV_EN is defined.
module alu_md
    import alu_md_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_FAST = 0
) (
    input  logic     clk,
    input  logic     reset,
    alu_md_if.slave  bus
);
    localparam int CW = $clog2(XLEN);

    state_t            state, state_nx;
    logic [XLEN-1:0]   a_r, b_r, hi, lo, mc, res_r, q_r, core_q, fast_q, final_q, fix_q, a_mag, b_mag;
    logic [4:0]        op_r;
    logic [CW-1:0]     cnt;
    logic              iter_r, sgn_p, z_r, err_r, done_r, go_iter, a_neg, b_neg, fast_err;
    logic [XLEN:0]     msum;
    logic [2*XLEN-1:0] prod_s, fprod;
`ifdef ALU_MD_DIV_EN
    logic              sgn_r, b_zero, ovf;
    logic [XLEN:0]     dshift, dsub;
    assign b_zero = bus.B == '0;
    assign ovf    = ~bus.op[0] & (bus.A == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.B);
    assign dshift = {hi, lo[XLEN-1]};
    assign dsub   = dshift - {1'b0, mc};
`endif

    // Decide at accept time whether the op needs the shift/add engine
    always_comb begin
        go_iter = 1'b0;
        if (bus.op[4] && !bus.op[3]) begin
            if (!bus.op[2]) go_iter = (MUL_FAST == 0);
`ifdef ALU_MD_DIV_EN
            else            go_iter = !b_zero && !ovf;
`endif
        end
    end

    // Operate on magnitudes; signs are re-applied in FIX
    always_comb begin
        a_neg = 1'b0;
        b_neg = 1'b0;
        if (!bus.op[2]) begin
            a_neg = bus.A[XLEN-1] & (bus.op[1:0] == 2'd1 || bus.op[1:0] == 2'd2);
            b_neg = bus.B[XLEN-1] & (bus.op[1:0] == 2'd1);
        end
`ifdef ALU_MD_DIV_EN
        else begin
            a_neg = bus.A[XLEN-1] & ~bus.op[0];
            b_neg = bus.B[XLEN-1] & ~bus.op[0];
        end
`endif
        a_mag = a_neg ? -bus.A : bus.A;
        b_mag = b_neg ? -bus.B : bus.B;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = go_iter ? CALC : DONE;
            CALC:    if (cnt == '0) state_nx = FIX;
            FIX:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign msum = {1'b0, hi} + (lo[0] ? {1'b0, mc} : {(XLEN+1){1'b0}});

    always_comb begin
        prod_s = sgn_p ? -{hi, lo} : {hi, lo};
        fix_q  = (op_r[1:0] == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
`ifdef ALU_MD_DIV_EN
        if (op_r[2]) fix_q = op_r[1] ? (sgn_r ? -hi : hi) : (sgn_p ? -lo : lo);
`endif
    end

    alu_core #(.XLEN(XLEN)) u_core (.a(a_r), .b(b_r), .op(op_r[3:0]), .result(core_q));

    if (MUL_FAST != 0) begin : g_fast_mul
        logic sa, sb;
        assign sa    = a_r[XLEN-1] & (op_r[1:0] == 2'd1 || op_r[1:0] == 2'd2);
        assign sb    = b_r[XLEN-1] & (op_r[1:0] == 2'd1);
        assign fprod = {{XLEN{sa}}, a_r} * {{XLEN{sb}}, b_r};
    end else begin : g_no_fast_mul
        assign fprod = '0;
    end

    // Single-cycle results: base ops, fast multiply, divide special cases, unsupported ops
    always_comb begin
        fast_q   = '0;
        fast_err = 1'b0;
        if (!op_r[4]) begin
            if (op_r[3:0] == OP_BAD) fast_err = 1'b1;
            else                     fast_q   = core_q;
        end else if (op_r[3]) begin
            fast_err = 1'b1;
        end else if (!op_r[2]) begin
            fast_q = (op_r[1:0] == 2'd0) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
        end else begin
`ifdef ALU_MD_DIV_EN
            if (b_r == '0) fast_q = op_r[1] ? a_r : '1;
            else           fast_q = op_r[1] ? '0 : a_r;
`else
            fast_err = 1'b1;
`endif
        end
        final_q = iter_r ? res_r : fast_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r <= '0; b_r <= '0; op_r <= '0; iter_r <= 1'b0; sgn_p <= 1'b0;
            hi <= '0; lo <= '0; mc <= '0; cnt <= '0; res_r <= '0;
            q_r <= '0; z_r <= 1'b1; err_r <= 1'b0; done_r <= 1'b0;
`ifdef ALU_MD_DIV_EN
            sgn_r <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    a_r <= bus.A; b_r <= bus.B; op_r <= bus.op; iter_r <= go_iter;
                    hi <= '0; lo <= a_mag; mc <= b_mag; sgn_p <= a_neg ^ b_neg;
                    cnt <= CW'(XLEN-1);
`ifdef ALU_MD_DIV_EN
                    sgn_r <= a_neg;
`endif
                end
                CALC: begin
                    cnt <= cnt - 1'b1;
                    if (!op_r[2]) begin
                        hi <= msum[XLEN:1];
                        lo <= {msum[0], lo[XLEN-1:1]};
                    end
`ifdef ALU_MD_DIV_EN
                    else begin
                        hi <= dsub[XLEN] ? dshift[XLEN-1:0] : dsub[XLEN-1:0];
                        lo <= {lo[XLEN-2:0], ~dsub[XLEN]};
                    end
`endif
                end
                FIX:  res_r <= fix_q;
                DONE: begin
                    q_r    <= final_q;
                    z_r    <= final_q == '0;
                    err_r  <= iter_r ? 1'b0 : fast_err;
                    done_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = state != IDLE;
    assign bus.done = done_r;
    assign bus.Q    = q_r;
    assign bus.Z    = z_r;
    assign bus.err  = err_r;
endmodule

// File: tb/tb_alu_md.sv
// Directed-vector bench for alu_md (XLEN=32, iterative multiply); divider checks follow ALU_MD_DIV_EN.
module tb_alu_md;
    import alu_md_pkg::*;

    localparam int XLEN = 32;
    localparam int LAT_IT = XLEN + LAT_ITER_EXTRA;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    alu_md_if #(.XLEN(XLEN)) bus ();
    alu_md #(.XLEN(XLEN), .MUL_FAST(0)) dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic logic [4:0] bop(input logic [3:0] o);
        return {1'b0, o};
    endfunction

    function automatic logic [4:0] mop(input logic [2:0] o);
        return {2'b10, o};
    endfunction

    // Launch one op and return the number of edges until done (-1 on timeout)
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.op = '0; bus.A = '0; bus.B = '0;
        #12;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Q !== 32'h0 || bus.Z !== 1'b1 || bus.err !== 1'b0)
            $display("FAIL reset_state busy=%b done=%b Q=%h Z=%b err=%b, want 0 0 00000000 1 0",
                     bus.busy, bus.done, bus.Q, bus.Z, bus.err);
        else passes++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_add_sub();
        int lat;
        do_op(bop(OP_ADD), 32'h7FFF_FFFF, 32'h1, lat);
        checks++;
        if (lat !== 1 || bus.Q !== 32'h8000_0000 || bus.Z !== 1'b0)
            $display("FAIL add_ovf lat=%0d Q=%h Z=%b, want 1 80000000 0", lat, bus.Q, bus.Z);
        else passes++;
        do_op(bop(OP_SUB), 32'd5, 32'd5, lat);
        checks++;
        if (lat !== 1 || bus.Q !== 32'h0 || bus.Z !== 1'b1)
            $display("FAIL sub_zero lat=%0d Q=%h Z=%b, want 1 00000000 1", lat, bus.Q, bus.Z);
        else passes++;
    endtask

    task automatic test_base_ops();
        int lat;
        vec_t v[15];
        v = '{
            '{bop(OP_AND),  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000},
            '{bop(OP_OR),   32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0},
            '{bop(OP_XOR),  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0},
            '{bop(OP_SLL),  32'h0000_0001, 32'h0000_0021, 32'h0000_0002},
            '{bop(OP_SRL),  32'h8000_0000, 32'h0000_0004, 32'h0800_0000},
            '{bop(OP_SRA),  32'h8000_0000, 32'h0000_0004, 32'hF800_0000},
            '{bop(OP_SLT),  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001},
            '{bop(OP_LT),   32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000},
            '{bop(OP_SLTU), 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
            '{bop(OP_JALR), 32'h0000_1000, 32'h0000_0007, 32'h0000_1006},
            '{bop(OP_EQ),   32'h0000_0005, 32'h0000_0005, 32'h0000_0001},
            '{bop(OP_NE),   32'h0000_0005, 32'h0000_0005, 32'h0000_0000},
            '{bop(OP_GE),   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
            '{bop(OP_GEU),  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001},
            '{bop(OP_SUB),  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE}
        };
        for (int i = 0; i < 15; i++) begin
            do_op(v[i].op, v[i].a, v[i].b, lat);
            checks++;
            if (lat !== 1 || bus.Q !== v[i].q || bus.err !== 1'b0)
                $display("FAIL base_op[%0d] op=%h lat=%0d Q=%h err=%b, want 1 %h 0",
                         i, v[i].op, lat, bus.Q, bus.err, v[i].q);
            else passes++;
        end
    endtask

    task automatic test_unsupported();
        int lat;
        do_op(bop(OP_BAD), 32'd3, 32'd4, lat);
        checks++;
        if (lat !== 1 || bus.Q !== 32'h0 || bus.Z !== 1'b1 || bus.err !== 1'b1)
            $display("FAIL bad_base lat=%0d Q=%h Z=%b err=%b, want 1 00000000 1 1", lat, bus.Q, bus.Z, bus.err);
        else passes++;
        do_op(5'b11000, 32'd3, 32'd4, lat);
        checks++;
        if (lat !== 1 || bus.err !== 1'b1)
            $display("FAIL bad_m lat=%0d err=%b, want 1 1", lat, bus.err);
        else passes++;
    endtask

    task automatic test_mul();
        int lat;
        do_op(mop(M_MULH), 32'h8000_0000, 32'h8000_0000, lat);
        checks++;
        if (lat !== LAT_IT || bus.Q !== 32'h4000_0000 || bus.err !== 1'b0)
            $display("FAIL mulh lat=%0d Q=%h err=%b, want %0d 40000000 0", lat, bus.Q, bus.err, LAT_IT);
        else passes++;
        do_op(mop(M_MULHSU), 32'hFFFF_FFFF, 32'h2, lat);
        checks++;
        if (lat !== LAT_IT || bus.Q !== 32'hFFFF_FFFF)
            $display("FAIL mulhsu lat=%0d Q=%h, want %0d ffffffff", lat, bus.Q, LAT_IT);
        else passes++;
        do_op(mop(M_MUL), 32'd6, 32'd7, lat);
        checks++;
        if (lat !== LAT_IT || bus.Q !== 32'd42)
            $display("FAIL mul lat=%0d Q=%h, want %0d 0000002a", lat, bus.Q, LAT_IT);
        else passes++;
        do_op(mop(M_MULHU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        checks++;
        if (lat !== LAT_IT || bus.Q !== 32'hFFFF_FFFE)
            $display("FAIL mulhu lat=%0d Q=%h, want %0d fffffffe", lat, bus.Q, LAT_IT);
        else passes++;
        do_op(mop(M_MULH), 32'hFFFF_FFF9, 32'h0000_0002, lat);
        checks++;
        if (lat !== LAT_IT || bus.Q !== 32'hFFFF_FFFF)
            $display("FAIL mulh_neg lat=%0d Q=%h, want %0d ffffffff", lat, bus.Q, LAT_IT);
        else passes++;
    endtask

`ifdef ALU_MD_DIV_EN
    task automatic test_div();
        int lat;
        vec_t v[8];
        int   vl[8];
        v = '{
            '{mop(M_DIV),  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
            '{mop(M_REM),  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
            '{mop(M_DIVU), 32'd100,       32'd7,         32'd14},
            '{mop(M_REMU), 32'd100,       32'd7,         32'd2},
            '{mop(M_DIVU), 32'd7,         32'd0,         32'hFFFF_FFFF},
            '{mop(M_REMU), 32'd9,         32'd0,         32'd9},
            '{mop(M_DIV),  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
            '{mop(M_REM),  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000}
        };
        vl = '{LAT_IT, LAT_IT, LAT_IT, LAT_IT, 1, 1, 1, 1};
        for (int i = 0; i < 8; i++) begin
            do_op(v[i].op, v[i].a, v[i].b, lat);
            checks++;
            if (lat !== vl[i] || bus.Q !== v[i].q || bus.err !== 1'b0)
                $display("FAIL div[%0d] op=%h lat=%0d Q=%h err=%b, want %0d %h 0",
                         i, v[i].op, lat, bus.Q, bus.err, vl[i], v[i].q);
            else passes++;
        end
    endtask
`else
    task automatic test_div();
        int lat;
        do_op(mop(M_REMU), 32'd9, 32'd4, lat);
        checks++;
        if (lat !== 1 || bus.Q !== 32'h0 || bus.Z !== 1'b1 || bus.err !== 1'b1)
            $display("FAIL nodiv_remu lat=%0d Q=%h Z=%b err=%b, want 1 00000000 1 1", lat, bus.Q, bus.Z, bus.err);
        else passes++;
        do_op(mop(M_DIV), 32'd7, 32'd2, lat);
        checks++;
        if (lat !== 1 || bus.Q !== 32'h0 || bus.err !== 1'b1)
            $display("FAIL nodiv_div lat=%0d Q=%h err=%b, want 1 00000000 1", lat, bus.Q, bus.err);
        else passes++;
    endtask
`endif

    task automatic test_busy_ignore();
        int lat;
        logic [4:0]  op;
        logic [31:0] q;
`ifdef ALU_MD_DIV_EN
        op = mop(M_DIV); q = 32'hFFFF_FFFD;
`else
        op = mop(M_MUL); q = 32'hFFFF_FFF2;
`endif
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.A = 32'hFFFF_FFF9; bus.B = 32'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = n;
                break;
            end
            if (n == 4) begin
                bus.start = 1'b1; bus.op = bop(OP_ADD); bus.A = 32'd1; bus.B = 32'd1;
            end
            if (n == 5) bus.start = 1'b0;
        end
        checks++;
        if (lat !== LAT_IT || bus.Q !== q)
            $display("FAIL busy_ignore lat=%0d Q=%h, want %0d %h", lat, bus.Q, LAT_IT, q);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.Q !== q)
            $display("FAIL busy_ignore_after done=%b busy=%b Q=%h, want 0 0 %h", bus.done, bus.busy, bus.Q, q);
        else passes++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.start = 1'b1; bus.op = bop(OP_ADD); bus.A = 32'd1; bus.B = 32'd2;
        @(posedge clk); #1;
        bus.op = bop(OP_SUB); bus.A = 32'd10; bus.B = 32'd3;
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b1 || bus.Q !== 32'd3)
            $display("FAIL b2b_first done=%b Q=%h, want 1 00000003", bus.done, bus.Q);
        else passes++;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.Q !== 32'd3)
            $display("FAIL b2b_accept done=%b busy=%b Q=%h, want 0 1 00000003", bus.done, bus.busy, bus.Q);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b1 || bus.Q !== 32'd7)
            $display("FAIL b2b_second done=%b Q=%h, want 1 00000007", bus.done, bus.Q);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int dones;
        int lat;
        logic [4:0] op;
`ifdef ALU_MD_DIV_EN
        op = mop(M_DIVU);
`else
        op = mop(M_MULHU);
`endif
        do_op(bop(OP_OR), 32'h0000_00A5, 32'h0, lat);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.A = 32'hFFFF_FFFF; bus.B = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int n = 1; n < 10; n++) begin
            @(posedge clk);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Q !== 32'h0 || bus.Z !== 1'b1 || bus.err !== 1'b0)
            $display("FAIL reset_mid busy=%b done=%b Q=%h Z=%b err=%b, want 0 0 00000000 1 0",
                     bus.busy, bus.done, bus.Q, bus.Z, bus.err);
        else passes++;
        @(negedge clk);
        reset = 1'b0;
        bus.start = 1'b1; bus.op = bop(OP_ADD); bus.A = 32'd2; bus.B = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b1 || bus.Q !== 32'd5 || bus.Z !== 1'b0)
            $display("FAIL reset_first_start done=%b Q=%h Z=%b, want 1 00000005 0", bus.done, bus.Q, bus.Z);
        else passes++;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        checks++;
        if (dones !== 0 || bus.Q !== 32'd5)
            $display("FAIL reset_no_stale dones=%0d Q=%h, want 0 00000005", dones, bus.Q);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_base_ops();
        test_unsupported();
        test_mul();
        test_div();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached, passed %0d of %0d", passes, checks);
        $fatal(1);
    end
endmodule
